// File: rtl/fp_align_pipe_pkg.sv
// fp_pkg: shared widths and types for the FP add/sub alignment datapath
package fp_pkg;
   localparam int EXP_W   = 8;
   localparam int MAN_W   = 24;
   localparam int GRS_W   = 3;
   localparam int ALIGN_W = MAN_W + GRS_W;
   typedef logic [EXP_W-1:0]   exp_t;
   typedef logic [MAN_W-1:0]   man_t;
   typedef logic [ALIGN_W-1:0] align_t;
endpackage

// File: rtl/fp_align_pipe_if.sv
// fp_align_if: operand-in / aligned-out handshake bundle for the alignment stage
interface fp_align_if import fp_pkg::*; #(
   parameter int EXP_W = fp_pkg::EXP_W,
   parameter int MAN_W = fp_pkg::MAN_W,
   parameter int GRS_W = fp_pkg::GRS_W
);
   logic                   in_valid;
   logic                   in_ready;
   logic [EXP_W-1:0]       exp_a;
   logic [EXP_W-1:0]       exp_b;
   logic [MAN_W-1:0]       man_a;
   logic [MAN_W-1:0]       man_b;
   logic                   out_valid;
   logic                   out_ready;
   logic [EXP_W-1:0]       exp_big;
   logic [MAN_W+GRS_W-1:0] man_big;
   logic [MAN_W+GRS_W-1:0] man_small;
   logic                   swap;
   logic [EXP_W-1:0]       shift;
   modport master (
      output in_valid, exp_a, exp_b, man_a, man_b, out_ready,
      input  in_ready, out_valid, exp_big, man_big, man_small, swap, shift
   );
   modport slave (
      input  in_valid, exp_a, exp_b, man_a, man_b, out_ready,
      output in_ready, out_valid, exp_big, man_big, man_small, swap, shift
   );
endinterface

// File: rtl/fp_align_pipe_shift_sticky.sv
// fp_shift_sticky: right shift with sticky OR into bit 0, saturating once every bit is gone
module fp_shift_sticky import fp_pkg::*; #(
   parameter int W    = fp_pkg::ALIGN_W,
   parameter int SH_W = fp_pkg::EXP_W
) (
   input  logic [W-1:0]    ext,
   input  logic [SH_W-1:0] diff,
   output logic [W-1:0]    res
);
   logic [W-1:0] sh;
   logic         lost;
   // shifted-out bits collapse into the sticky bit; a shift past the width leaves only sticky
   always_comb begin
      sh   = ext >> diff;
      lost = |(ext & ~({W{1'b1}} << diff));
      res  = (int'(diff) >= W) ? W'(|ext) : {sh[W-1:1], sh[0] | lost};
   end
endmodule

// File: rtl/fp_align_pipe.sv
// fp_align_pipe: two-stage magnitude compare and mantissa alignment with full backpressure
module fp_align_pipe import fp_pkg::*; #(
   parameter int EXP_W       = fp_pkg::EXP_W,
   parameter int MAN_W       = fp_pkg::MAN_W,
   parameter int GRS_W       = fp_pkg::GRS_W,
   parameter bit SWAP_ON_TIE = 1'b1
) (
   input logic       clk,
   input logic       rst_n,
   fp_align_if.slave bus
);
   localparam int W = MAN_W + GRS_W;
   logic             s1_valid, s2_valid, s1_adv, s2_adv, swap_c, s1_swap;
   logic [EXP_W-1:0] s1_exp, s1_diff;
   logic [MAN_W-1:0] s1_big, s1_small;
   logic [W-1:0]     shifted;
   // each stage moves when its successor has room; in_ready ripples back without a bubble
   always_comb begin
      s2_adv = !s2_valid || bus.out_ready;
      s1_adv = !s1_valid || s2_adv;
      swap_c = (bus.exp_b > bus.exp_a) ||
               (SWAP_ON_TIE && bus.exp_a == bus.exp_b && bus.man_b > bus.man_a);
   end
   assign bus.in_ready  = s1_adv;
   assign bus.out_valid = s2_valid;
   // stage 1: order operands by magnitude and take the exponent difference
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_swap  <= 1'b0;
         s1_exp   <= '0;
         s1_diff  <= '0;
         s1_big   <= '0;
         s1_small <= '0;
      end else begin
         if (s1_adv) s1_valid <= bus.in_valid;
         if (s1_adv && bus.in_valid) begin
            s1_swap  <= swap_c;
            s1_exp   <= swap_c ? bus.exp_b : bus.exp_a;
            s1_diff  <= swap_c ? bus.exp_b - bus.exp_a : bus.exp_a - bus.exp_b;
            s1_big   <= swap_c ? bus.man_b : bus.man_a;
            s1_small <= swap_c ? bus.man_a : bus.man_b;
         end
      end
   end
   fp_shift_sticky #(.W(W), .SH_W(EXP_W)) u_shift (
      .ext  ({s1_small, {GRS_W{1'b0}}}),
      .diff (s1_diff),
      .res  (shifted)
   );
   // stage 2: register the aligned pair; held while downstream stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid      <= 1'b0;
         bus.exp_big   <= '0;
         bus.man_big   <= '0;
         bus.man_small <= '0;
         bus.swap      <= 1'b0;
         bus.shift     <= '0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            bus.exp_big   <= s1_exp;
            bus.man_big   <= {s1_big, {GRS_W{1'b0}}};
            bus.man_small <= shifted;
            bus.swap      <= s1_swap;
            bus.shift     <= s1_diff;
         end
      end
   end
endmodule

// File: tb/tb_fp_align_pipe.sv
// tb_fp_align_pipe: directed alignment, tie, backpressure and reset checks
module tb_fp_align_pipe;
   import fp_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vecs = 0;
   int   errs = 0;
   always #5 clk = ~clk;
   fp_align_if b0 ();
   fp_align_if b1 ();
   assign b1.in_valid  = b0.in_valid;
   assign b1.exp_a     = b0.exp_a;
   assign b1.exp_b     = b0.exp_b;
   assign b1.man_a     = b0.man_a;
   assign b1.man_b     = b0.man_b;
   assign b1.out_ready = b0.out_ready;
   fp_align_pipe #(.SWAP_ON_TIE(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   fp_align_pipe #(.SWAP_ON_TIE(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   logic [70:0] o0, o1;
   assign o0 = {b0.exp_big, b0.swap, b0.shift, b0.man_big, b0.man_small};
   assign o1 = {b1.exp_big, b1.swap, b1.shift, b1.man_big, b1.man_small};
   logic [63:0] stim [4];
   logic [70:0] expv [4];
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic send(input logic [63:0] v);
      chk("accept_ready", b0.in_ready, 1'b1);
      b0.in_valid = 1'b1;
      {b0.exp_a, b0.exp_b, b0.man_a, b0.man_b} = v;
      @(posedge clk); #1;
      b0.in_valid = 1'b0;
   endtask
   task automatic run_one(input string tag, input logic [63:0] v, input logic [70:0] e);
      send(v);
      chk({tag, "_lat1"}, b0.out_valid, 1'b0);
      @(posedge clk); #1;
      chk({tag, "_valid"}, b0.out_valid, 1'b1);
      chk(tag, o0, e);
   endtask
   initial begin
      int   sent, recv;
      logic hs_in, hs_out;
      stim[0] = {8'd130, 8'd128, 24'h800000, 24'hC00000};
      stim[1] = {8'd132, 8'd128, 24'h800000, 24'h000001};
      stim[2] = {8'd10,  8'd60,  24'hFFFFFF, 24'h800000};
      stim[3] = {8'd100, 8'd101, 24'h800000, 24'h800000};
      expv[0] = {8'd130, 1'b0, 8'd2,  27'h4000000, 27'h1800000};
      expv[1] = {8'd132, 1'b0, 8'd4,  27'h4000000, 27'h0000001};
      expv[2] = {8'd60,  1'b1, 8'd50, 27'h4000000, 27'h0000001};
      expv[3] = {8'd101, 1'b1, 8'd1,  27'h4000000, 27'h2000000};
      b0.in_valid  = 1'b0;
      b0.exp_a     = '0;
      b0.exp_b     = '0;
      b0.man_a     = '0;
      b0.man_b     = '0;
      b0.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", b0.in_ready, 1'b1);
      chk("rst_outputs", {b0.out_valid, o0}, 72'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_one("basic", stim[0], expv[0]);
      run_one("sticky", stim[1], expv[1]);
      run_one("sat_swap", stim[2], expv[2]);
      run_one("sat_zero", {8'd10, 8'd60, 24'h000000, 24'h800000},
              {8'd60, 1'b1, 8'd50, 27'h4000000, 27'h0000000});
      run_one("tie_swap", {8'd127, 8'd127, 24'h900000, 24'hA00000},
              {8'd127, 1'b1, 8'd0, 27'h5000000, 27'h4800000});
      chk("tie_noswap", o1, {8'd127, 1'b0, 8'd0, 27'h4800000, 27'h5000000});
      @(posedge clk); #1;
      chk("drain_empty", b0.out_valid, 1'b0);
      sent = 0;
      recv = 0;
      for (int c = 0; c < 40 && recv < 4; c++) begin
         b0.in_valid = (sent < 4);
         {b0.exp_a, b0.exp_b, b0.man_a, b0.man_b} = stim[(sent > 3) ? 3 : sent];
         b0.out_ready = (c >= 5);
         @(negedge clk);
         hs_in  = b0.in_valid && b0.in_ready;
         hs_out = b0.out_valid && b0.out_ready;
         if (c == 2) chk("bp_full", {b0.in_ready, sent[2:0]}, {1'b0, 3'd2});
         if (c >= 2 && c < 5) chk("bp_hold", {b0.out_valid, o0}, {1'b1, expv[0]});
         if (hs_out) begin
            chk("bp_order", o0, expv[recv]);
            recv++;
         end
         @(posedge clk); #1;
         if (hs_in) sent++;
      end
      b0.in_valid = 1'b0;
      chk("bp_count", recv, 4);
      chk("bp_no_dup", b0.out_valid, 1'b0);
      b0.out_ready = 1'b0;
      send(stim[0]);
      send(stim[1]);
      chk("pre_rst_full", {b0.out_valid, b0.in_ready}, 2'b10);
      rst_n = 1'b0;
      #1;
      chk("async_rst_out", {b0.out_valid, o0}, 72'h0);
      chk("async_rst_ready", b0.in_ready, 1'b1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      b0.out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk("no_stale", {b0.out_valid, b0.in_ready}, 2'b01);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
